mux_16to1: RTL and testbench

MUX_16TO1 -- requirements
Module: mux_16to1

---
 rtl/mux_16to1_pkg.sv | 8 +
 rtl/mux_16to1_decoder.sv | 14 +
 rtl/mux_16to1.sv | 66 ++++++
 tb/tb_mux_16to1.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/mux_16to1_pkg.sv
// Shared constants for the 16:1 multiplexer and its one-hot address decoder.
package mux_16to1_pkg;

    localparam int unsigned NUM_INPUTS    = 16;
    localparam int unsigned SEL_W         = 4;
    localparam int unsigned DEFAULT_WIDTH = 32;

endpackage : mux_16to1_pkg

// File: rtl/mux_16to1_decoder.sv
// 4-to-16 one-hot decoder: output bit N is set when the 4-bit input equals N.
module decoder_4to16
    import mux_16to1_pkg::*;
(
    input  logic [SEL_W-1:0]      i_sel,
    output logic [NUM_INPUTS-1:0] o_onehot
);

    always_comb begin
        o_onehot        = '0;
        o_onehot[i_sel] = 1'b1;
    end

endmodule : decoder_4to16

// File: rtl/mux_16to1.sv
// 16:1 data multiplexer with one-hot select decode and registered copies of both results.
module mux_16to1
    import mux_16to1_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [SEL_W-1:0]      select,
    input  logic [WIDTH-1:0]      q0,
    input  logic [WIDTH-1:0]      q1,
    input  logic [WIDTH-1:0]      q2,
    input  logic [WIDTH-1:0]      q3,
    input  logic [WIDTH-1:0]      q4,
    input  logic [WIDTH-1:0]      q5,
    input  logic [WIDTH-1:0]      q6,
    input  logic [WIDTH-1:0]      q7,
    input  logic [WIDTH-1:0]      q8,
    input  logic [WIDTH-1:0]      q9,
    input  logic [WIDTH-1:0]      q10,
    input  logic [WIDTH-1:0]      q11,
    input  logic [WIDTH-1:0]      q12,
    input  logic [WIDTH-1:0]      q13,
    input  logic [WIDTH-1:0]      q14,
    input  logic [WIDTH-1:0]      q15,
    output logic [WIDTH-1:0]      out,
    output logic [NUM_INPUTS-1:0] onehot,
    output logic [WIDTH-1:0]      out_q,
    output logic [NUM_INPUTS-1:0] onehot_q
);

    logic [WIDTH-1:0]      w_q [NUM_INPUTS];
    logic [NUM_INPUTS-1:0] w_onehot;
    logic [WIDTH-1:0]      r_out_q;
    logic [NUM_INPUTS-1:0] r_onehot_q;

    assign w_q = '{q0, q1, q2, q3, q4, q5, q6, q7,
                   q8, q9, q10, q11, q12, q13, q14, q15};

    always_comb begin
        out = w_q[select];
    end

    decoder_4to16 u_decoder (
        .i_sel    (select),
        .o_onehot (w_onehot)
    );

    assign onehot = w_onehot;

    // Reset wins over en; en=0 holds the last captured pair.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_q    <= '0;
            r_onehot_q <= '0;
        end else if (en) begin
            r_out_q    <= out;
            r_onehot_q <= w_onehot;
        end
    end

    assign out_q    = r_out_q;
    assign onehot_q = r_onehot_q;

endmodule : mux_16to1

// File: tb/tb_mux_16to1.sv
// Self-checking bench for mux_16to1: per-cycle model comparison plus directed literal checks.
module tb_mux_16to1;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [3:0]  sel;
    logic [31:0] q [16];
    logic [31:0] out, out_q;
    logic [15:0] onehot, onehot_q;

    int errors = 0;
    int checks = 0;

    logic [31:0] m_out_q;
    logic [15:0] m_onehot_q;
    bit          m_valid = 1'b0;

    always #5 clk = ~clk;

    mux_16to1 #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .en(en), .select(sel),
        .q0(q[0]),   .q1(q[1]),   .q2(q[2]),   .q3(q[3]),
        .q4(q[4]),   .q5(q[5]),   .q6(q[6]),   .q7(q[7]),
        .q8(q[8]),   .q9(q[9]),   .q10(q[10]), .q11(q[11]),
        .q12(q[12]), .q13(q[13]), .q14(q[14]), .q15(q[15]),
        .out(out), .onehot(onehot), .out_q(out_q), .onehot_q(onehot_q)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model of the registered outputs: what was selected at the last enabled edge.
    always @(posedge clk) begin
        if (reset) begin
            m_out_q    <= 32'h0;
            m_onehot_q <= 16'h0;
        end else if (en) begin
            m_out_q    <= q[sel];
            m_onehot_q <= 16'(1) << sel;
        end
        m_valid <= 1'b1;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_out",      out,             q[sel]);
            check("model_onehot",   {16'h0, onehot}, {16'h0, 16'(1) << sel});
            check("model_out_q",    out_q,           m_out_q);
            check("model_onehot_q", {16'h0, onehot_q}, {16'h0, m_onehot_q});
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    logic [31:0] saved;

    initial begin
        reset = 1'b1;
        en    = 1'b0;
        sel   = 4'd0;
        for (int i = 0; i < 16; i++) q[i] = 32'h0;
        step();
        step();
        check("reset_out_q",    out_q,             32'h0);
        check("reset_onehot_q", {16'h0, onehot_q}, 32'h0);

        // Sweep with qN = 0x1000_0000 + N, registering every cycle.
        reset = 1'b0;
        en    = 1'b1;
        for (int i = 0; i < 16; i++) q[i] = 32'h1000_0000 + 32'(i);
        for (int s = 0; s < 16; s++) begin
            sel = 4'(s);
            #1;
            check("sweep_out",    out,             32'h1000_0000 + 32'(s));
            check("sweep_onehot", {16'h0, onehot}, 32'(1) << s);
            step();
        end

        sel = 4'd2;
        #1;
        check("lit_out_sel2",    out,             32'h1000_0002);
        check("lit_onehot_sel2", {16'h0, onehot}, 32'h0000_0004);

        q[15] = 32'hFFFF_FFFF;
        sel   = 4'd15;
        #1;
        check("sel15_onehot", {16'h0, onehot}, 32'h0000_8000);
        check("sel15_out",    out,             32'hFFFF_FFFF);
        q[0] = 32'h0;
        sel  = 4'd0;
        #1;
        check("sel0_onehot", {16'h0, onehot}, 32'h0000_0001);
        check("sel0_out",    out,             32'h0);
        step();

        // Unselected input must not disturb out; selected input propagates immediately.
        sel = 4'd3;
        #1;
        saved = out;
        q[7]  = 32'h7777_0000;
        #1;
        check("unsel_q7", out, saved);
        q[3] = 32'hDEAD_BEEF;
        #0;
        check("sel_q3_same_delta", out, 32'hDEAD_BEEF);
        step();

        // Load then hold.
        en    = 1'b1;
        sel   = 4'd5;
        q[5]  = 32'hA5A5_A5A5;
        step();
        check("load_out_q",    out_q,             32'hA5A5_A5A5);
        check("load_onehot_q", {16'h0, onehot_q}, 32'h0000_0020);
        en  = 1'b0;
        sel = 4'd6;
        step();
        step();
        check("hold_out_q",    out_q,             32'hA5A5_A5A5);
        check("hold_onehot_q", {16'h0, onehot_q}, 32'h0000_0020);

        // Reset beats enable; combinational path keeps following select.
        reset = 1'b1;
        en    = 1'b1;
        sel   = 4'd9;
        q[9]  = 32'h0909_1234;
        step();
        check("rst_pri_out_q",    out_q,             32'h0);
        check("rst_pri_onehot_q", {16'h0, onehot_q}, 32'h0);
        check("rst_comb_out",     out,               32'h0909_1234);
        check("rst_comb_onehot",  {16'h0, onehot},   32'h0000_0200);
        reset = 1'b0;
        step();
        check("post_rst_out_q",    out_q,             32'h0909_1234);
        check("post_rst_onehot_q", {16'h0, onehot_q}, 32'h0000_0200);

        // A few mixed vectors with en toggling.
        for (int k = 0; k < 8; k++) begin
            en       = k[0];
            sel      = 4'((k * 7) % 16);
            q[sel]   = 32'hC0DE_0000 | 32'(k);
            q[15 - k] = 32'h5A5A_0000 ^ 32'(k * 3);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_mux_16to1
